dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
REQ-002 Parameter WAIT_CYCLES, 1, extra access cycles between accept and response (0..15).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  MEM-stage access request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 memwrite  input  1  1 = store, 0 = load.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, valid bytes right-aligned.
REQ-010 swhb  input  4  store size mask: 0001 sb, 0011 sh, 1111 sw, 0000 no write.
REQ-011 lwhb  input  2  load size: 01 byte, 10 half, 00 or 11 word.
REQ-012 lunsigned  input  1  zero-extend sub-word loads.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer takes the response.
REQ-015 rdata  output  32  extended load result; 0 for stores.
REQ-016 err  output  1  misaligned-access flag, valid with rsp_valid.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE with req_valid=1, the block SHALL register memwrite, addr, wdata, swhb, lwhb, lunsigned and move to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-019 WAIT SHALL last exactly WAIT_CYCLES cycles via a down-counter, then move to RESP; latency from accept edge to rsp_valid=1 SHALL be WAIT_CYCLES+1 cycles.
REQ-020 The array access (write commit or read sample) SHALL occur on the edge entering RESP, exactly once per request.
REQ-021 RESP SHALL hold rsp_valid, rdata and err stable until rsp_ready=1, then return to IDLE on that edge; no new request is accepted in that same cycle.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap-around modulo DEPTH_WORDS).
REQ-023 Store byte enables SHALL be swhb shifted left by addr[1:0], truncated to 4 bits; store data SHALL be replicated (byte x4, half x2) so each enabled lane gets the right-aligned value.
REQ-024 Load SHALL extract byte at addr[1:0] or half at addr[1], then sign-extend (lunsigned=0) or zero-extend (lunsigned=1); word loads return the whole word.
REQ-025 A store with swhb=0000 SHALL modify nothing and still produce a response.
REQ-026 Misaligned means: half with addr[0]=1, or word with addr[1:0]!=00 (size from swhb for stores, lwhb for loads).
REQ-027 Inputs outside IDLE SHALL be ignored.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counter 0, rsp_valid=0, rdata=0, err=0, req_ready=1 on release.
REQ-029 Reset during WAIT SHALL abort the request with no array write; array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL set err=1, suppress any write, and return rdata=0.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, err SHALL be tied 0 and misaligned accesses SHALL proceed with lanes computed per REQ-023/024 (shifted-out lanes dropped).

Verification
REQ-032 sw 0x12345678 @0x10, then lw @0x10 (WAIT_CYCLES=1) -> rsp_valid 2 cycles after each accept, rdata=0x12345678.
REQ-033 After REQ-032: lb @0x13 -> 0x00000012; sb 0x80 @0x11 then lb @0x11 -> 0xFFFFFF80, lbu @0x11 -> 0x00000080, lw @0x10 -> 0x12348078.
REQ-034 sh 0xBEEF @0x12, lh @0x12 -> 0xFFFFBEEF, lhu -> 0x0000BEEF; lw @0x10+4*DEPTH_WORDS -> 0xBEEF8078 (wrap).
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, second req_valid ignored until handshake.
REQ-036 sw 0xFFFFFFFF @0x21 with DMEM_MISALIGN_TRAP_EN -> err=1, lw @0x20 returns prior value unchanged; without macro -> err=0, lw @0x20 -> 0xFFFFFF00 (from zero).
REQ-037 Assert reset=0 during WAIT of a sw @0x30 -> outputs reset immediately; later lw @0x30 returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores against a word array.
// Latency: response WAIT_CYCLES+1 cycles after the request cycle; one request in flight at a time.
// Backpressure: req_ready only in IDLE; response held until rsp_ready. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  swhb,
  input  logic [1:0]  lwhb,
  input  logic        lunsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        q_memwrite, q_lunsigned;
  logic [31:0] q_addr, q_wdata;
  logic [3:0]  q_swhb;
  logic [1:0]  q_lwhb;

  logic [31:0] mem [DEPTH_WORDS];

  // With no wait states the access uses the live inputs on the accept edge.
  logic        use_in;
  logic        a_memwrite, a_lunsigned;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_swhb;
  logic [1:0]  a_lwhb;
  assign use_in      = (state == IDLE);
  assign a_memwrite  = use_in ? memwrite  : q_memwrite;
  assign a_lunsigned = use_in ? lunsigned : q_lunsigned;
  assign a_addr      = use_in ? addr      : q_addr;
  assign a_wdata     = use_in ? wdata     : q_wdata;
  assign a_swhb      = use_in ? swhb      : q_swhb;
  assign a_lwhb      = use_in ? lwhb      : q_lwhb;

  logic          go_resp;
  assign go_resp = reset && (((state == IDLE) && req_valid && (WC == 4'd0)) ||
                             ((state == WAIT) && (cnt == 4'd1)));

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          unused_addr_bits;
  assign idx = a_addr[AW+1:2];
  assign off = a_addr[1:0];
  assign unused_addr_bits = ^a_addr[31:AW+2];

  logic        misaligned, trap, wr_en;
  logic [3:0]  be;
  logic [31:0] wd_rep, rd_word, ld_val, rsp_dat;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    misaligned = 1'b0;
    be         = a_swhb << off;
    wd_rep     = a_wdata;
    rd_word    = mem[idx];
    rd_byte    = rd_word[{off, 3'b000} +: 8];
    rd_half    = off[1] ? rd_word[31:16] : rd_word[15:0];
    ld_val     = rd_word;
    if (a_swhb == 4'b0001) wd_rep = {4{a_wdata[7:0]}};
    else if (a_swhb == 4'b0011) wd_rep = {2{a_wdata[15:0]}};
    if (a_memwrite) begin
      misaligned = ((a_swhb == 4'b0011) && off[0]) || ((a_swhb == 4'b1111) && (off != 2'b00));
      ld_val     = 32'd0;
    end else if (a_lwhb == 2'b01) begin
      ld_val = a_lunsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (a_lwhb == 2'b10) begin
      misaligned = off[0];
      ld_val     = a_lunsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
    end else begin
      misaligned = (off != 2'b00);
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  assign rsp_dat = trap ? 32'd0 : ld_val;
  assign wr_en   = go_resp && a_memwrite && !trap;

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rdata       <= 32'd0;
      err         <= 1'b0;
      q_memwrite  <= 1'b0;
      q_lunsigned <= 1'b0;
      q_addr      <= 32'd0;
      q_wdata     <= 32'd0;
      q_swhb      <= 4'd0;
      q_lwhb      <= 2'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          q_memwrite  <= memwrite;
          q_lunsigned <= lunsigned;
          q_addr      <= addr;
          q_wdata     <= wdata;
          q_swhb      <= swhb;
          q_lwhb      <= lwhb;
          req_ready   <= 1'b0;
          if (WC == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rdata     <= rsp_dat;
            err       <= trap;
          end else begin
            state <= WAIT;
            cnt   <= WC;
          end
        end
        WAIT: if (cnt == 4'd1) begin
          state     <= RESP;
          cnt       <= 4'd0;
          rsp_valid <= 1'b1;
          rdata     <= rsp_dat;
          err       <= trap;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rdata     <= 32'd0;
          err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard queue.
// Option DMEM_MISALIGN_TRAP_EN selects the trap-mode expectations.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  swhb = 4'd0;
  logic [1:0]  lwhb = 2'd0;
  logic        lunsigned = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rdata;
  logic        err;

  int ncmp = 0;
  int nfail = 0;
  logic [32:0] exp_q[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .memwrite(memwrite), .addr(addr), .wdata(wdata), .swhb(swhb), .lwhb(lwhb),
    .lunsigned(lunsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sh, input logic [1:0] lh, input logic lu);
    req_valid = 1'b1; memwrite = mw; addr = a; wdata = wd;
    swhb = sh; lwhb = lh; lunsigned = lu;
  endtask

  // Accept, check latency, then pop the scoreboard and compare the response.
  task automatic txn(input string tag, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] sh, input logic [1:0] lh, input logic lu,
                     input logic [31:0] exp_d, input logic exp_e);
    int lat;
    logic [32:0] e;
    exp_q.push_back({exp_e, exp_d});
    @(negedge clk);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    drive(mw, a, wd, sh, lh, lu);
    @(posedge clk);
    #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; memwrite = $urandom_range(0, 1);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WAITC + 1));
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " rdata"}, rdata, e[31:0]);
    check({tag, " err"}, {31'd0, err}, {31'd0, e[32]});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] held;
    logic        mis_trap;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_trap = 1'b1;
`else
    mis_trap = 1'b0;
`endif
    #2;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);

    txn("sw 10",   1, 32'h10, 32'h12345678, 4'b1111, 2'b00, 0, 32'h0, 0);
    txn("lw 10",   0, 32'h10, 32'h0, 4'b0000, 2'b00, 0, 32'h12345678, 0);
    txn("lb 13",   0, 32'h13, 32'h0, 4'b0000, 2'b01, 0, 32'h00000012, 0);
    txn("sb 11",   1, 32'h11, 32'h80, 4'b0001, 2'b00, 0, 32'h0, 0);
    txn("lb 11",   0, 32'h11, 32'h0, 4'b0000, 2'b01, 0, 32'hFFFFFF80, 0);
    txn("lbu 11",  0, 32'h11, 32'h0, 4'b0000, 2'b01, 1, 32'h00000080, 0);
    txn("lw 10b",  0, 32'h10, 32'h0, 4'b0000, 2'b11, 0, 32'h12348078, 0);
    txn("sh 12",   1, 32'h12, 32'hBEEF, 4'b0011, 2'b00, 0, 32'h0, 0);
    txn("lh 12",   0, 32'h12, 32'h0, 4'b0000, 2'b10, 0, 32'hFFFFBEEF, 0);
    txn("lhu 12",  0, 32'h12, 32'h0, 4'b0000, 2'b10, 1, 32'h0000BEEF, 0);
    txn("lw wrap", 0, 32'h10 + 4 * DEPTH, 32'h0, 4'b0000, 2'b00, 0, 32'hBEEF8078, 0);
    txn("s none",  1, 32'h10, 32'hFFFFFFFF, 4'b0000, 2'b00, 0, 32'h0, 0);
    txn("lw none", 0, 32'h10, 32'h0, 4'b0000, 2'b00, 0, 32'hBEEF8078, 0);

    // Response held under backpressure while a second request is presented.
    exp_q.push_back({1'b0, 32'hBEEF8078});
    @(negedge clk);
    drive(0, 32'h10, 32'h0, 4'b0000, 2'b00, 0);
    @(posedge clk);
    #1;
    drive(1, 32'h10, 32'hDEADDEAD, 4'b1111, 2'b00, 0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    e = exp_q.pop_front();
    held = rdata;
    check("hold first rdata", rdata, e[31:0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold rdata", rdata, held);
      check("hold req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("hold release rsp_valid", {31'd0, rsp_valid}, 32'd0);
    txn("lw after hold", 0, 32'h10, 32'h0, 4'b0000, 2'b00, 0, 32'hBEEF8078, 0);

    txn("sw 20 zero", 1, 32'h20, 32'h0, 4'b1111, 2'b00, 0, 32'h0, 0);
    txn("sw 21 mis",  1, 32'h21, 32'hFFFFFFFF, 4'b1111, 2'b00, 0, 32'h0, mis_trap);
    txn("lw 20",      0, 32'h20, 32'h0, 4'b0000, 2'b00, 0,
        mis_trap ? 32'h0 : 32'hFFFFFF00, 0);
    txn("lw 11 mis",  0, 32'h11, 32'h0, 4'b0000, 2'b00, 0,
        mis_trap ? 32'h0 : 32'hBEEF8078, mis_trap);

    // Reset asserted while a store sits in WAIT must abort it.
    txn("sw 30", 1, 32'h30, 32'hA5A5A5A5, 4'b1111, 2'b00, 0, 32'h0, 0);
    @(negedge clk);
    drive(1, 32'h30, 32'h11111111, 4'b1111, 2'b00, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort rdata", rdata, 32'd0);
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn("lw 30", 0, 32'h30, 32'h0, 4'b0000, 2'b00, 0, 32'hA5A5A5A5, 0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
